// File: rtl/gate_mon_pkg.sv
// Shared types and defaults for the gate-pair monitor.
package gate_mon_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    HI_ON,
    DEAD_H,
    LO_ON,
    DEAD_L,
    BOTH
  } state_t;

  // Segment state entered when the sampled pair changes to s.
  // A 00 only counts as a dead gap if it follows an on-segment.
  function automatic state_t seg_state(input state_t cur, input logic [1:0] s);
    state_t nxt;
    case (s)
      2'b10:   nxt = HI_ON;
      2'b01:   nxt = LO_ON;
      2'b11:   nxt = BOTH;
      default: nxt = (cur == HI_ON) ? DEAD_H : ((cur == LO_ON) ? DEAD_L : IDLE);
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that clears while disabled, reloads to 1 on load and
// holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         MClk,
  input  logic         RstN,
  input  logic         en,
  input  logic         load,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge MClk) begin
    if (!RstN || !en) begin
      count <= '0;
    end else if (load) begin
      count <= W'(1);
    end else if (count != MAX) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/gate_pair_monitor.sv
// Measures on-times, dead-time gaps and period of a complementary gate pair
// and flags shoot-through and short dead times.
module gate_pair_monitor
  import gate_mon_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             MClk,
  input  logic             RstN,
  input  logic             Enable,
  input  logic [1:0]       S,
  input  logic [CNT_W-1:0] MinDeadCount,
  input  logic             FaultClr,
  output logic [CNT_W-1:0] HighTimeHi,
  output logic [CNT_W-1:0] HighTimeLo,
  output logic [CNT_W-1:0] DeadTimeHL,
  output logic [CNT_W-1:0] DeadTimeLH,
  output logic [CNT_W-1:0] Period,
  output logic             MeasValid,
  output logic             ShootThru,
  output logic             DeadViol,
  output logic             Fault
);

  // s_q is the sampled pair, s_prev the sample before it
  logic [1:0]       s_q;
  logic [1:0]       s_prev;
  state_t           state;
  logic             first_seen;
  logic [CNT_W-1:0] seg_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic             seg_chg;
  logic             rise;

  logic             hl_evt;
  logic             lh_evt;
  logic [CNT_W-1:0] hl_val;
  logic [CNT_W-1:0] lh_val;
  logic             dead_set;
  logic             shoot_nxt;
  logic             dead_nxt;

  assign seg_chg = (s_q != s_prev);
  assign rise    = s_q[1] & ~s_prev[1];

  sat_counter #(.W(CNT_W)) u_seg_cnt (
    .MClk  (MClk),
    .RstN  (RstN),
    .en    (Enable),
    .load  (seg_chg),
    .count (seg_cnt)
  );

  sat_counter #(.W(CNT_W)) u_per_cnt (
    .MClk  (MClk),
    .RstN  (RstN),
    .en    (Enable),
    .load  (rise),
    .count (per_cnt)
  );

  // Dead-time update events and next sticky-flag values
  always_comb begin
    hl_evt = 1'b0;
    lh_evt = 1'b0;
    hl_val = '0;
    lh_val = '0;
    if (Enable && seg_chg) begin
      if (s_q == 2'b01 && state == DEAD_H) begin
        hl_evt = 1'b1;
        hl_val = seg_cnt;
      end
      if (s_q == 2'b01 && state == HI_ON) hl_evt = 1'b1;
      if (s_q == 2'b10 && state == DEAD_L) begin
        lh_evt = 1'b1;
        lh_val = seg_cnt;
      end
      if (s_q == 2'b10 && state == LO_ON) lh_evt = 1'b1;
    end
    dead_set = (hl_evt && (MinDeadCount != '0) && (hl_val < MinDeadCount)) ||
               (lh_evt && (MinDeadCount != '0) && (lh_val < MinDeadCount));
    shoot_nxt = (ShootThru && !FaultClr) || (s_q == 2'b11);
    dead_nxt  = (DeadViol && !FaultClr) || dead_set;
  end

  always_ff @(posedge MClk) begin
    if (!RstN) begin
      s_q        <= S;
      s_prev     <= S;
      state      <= IDLE;
      first_seen <= 1'b0;
      HighTimeHi <= '0;
      HighTimeLo <= '0;
      DeadTimeHL <= '0;
      DeadTimeLH <= '0;
      Period     <= '0;
      MeasValid  <= 1'b0;
      ShootThru  <= 1'b0;
      DeadViol   <= 1'b0;
      Fault      <= 1'b0;
    end else begin
      s_q       <= S;
      s_prev    <= s_q;
      MeasValid <= 1'b0;
      ShootThru <= shoot_nxt;
      DeadViol  <= dead_nxt;
      Fault     <= shoot_nxt | dead_nxt;
      if (hl_evt) DeadTimeHL <= hl_val;
      if (lh_evt) DeadTimeLH <= lh_val;
      if (!Enable) begin
        state      <= IDLE;
        first_seen <= 1'b0;
      end else begin
        if (seg_chg) begin
          // Transitions into BOTH do not publish an on-time
          if (state == HI_ON && s_q != 2'b11) HighTimeHi <= seg_cnt;
          if (state == LO_ON && s_q != 2'b11) HighTimeLo <= seg_cnt;
          state <= seg_state(state, s_q);
        end
        if (rise) begin
          if (first_seen) begin
            Period    <= per_cnt;
            MeasValid <= 1'b1;
          end
          first_seen <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_pair_monitor.sv
// Directed bench for gate_pair_monitor with a segment-level reference model.
module tb_gate_pair_monitor;

  localparam int unsigned W = 16;
  localparam int MAXV = 65535;

  logic          MClk = 1'b0;
  logic          RstN;
  logic          Enable;
  logic [1:0]    S;
  logic [W-1:0]  MinDeadCount;
  logic          FaultClr;
  logic [W-1:0]  HighTimeHi;
  logic [W-1:0]  HighTimeLo;
  logic [W-1:0]  DeadTimeHL;
  logic [W-1:0]  DeadTimeLH;
  logic [W-1:0]  Period;
  logic          MeasValid;
  logic          ShootThru;
  logic          DeadViol;
  logic          Fault;

  gate_pair_monitor #(.CNT_W(W)) dut (
    .MClk         (MClk),
    .RstN         (RstN),
    .Enable       (Enable),
    .S            (S),
    .MinDeadCount (MinDeadCount),
    .FaultClr     (FaultClr),
    .HighTimeHi   (HighTimeHi),
    .HighTimeLo   (HighTimeLo),
    .DeadTimeHL   (DeadTimeHL),
    .DeadTimeLH   (DeadTimeLH),
    .Period       (Period),
    .MeasValid    (MeasValid),
    .ShootThru    (ShootThru),
    .DeadViol     (DeadViol),
    .Fault        (Fault)
  );

  always #5 MClk = ~MClk;

  int n_cmp = 0;
  int n_bad = 0;
  int mv_count = 0;
  int mv0 = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic bit below(input int v);
    return (MinDeadCount != '0) && (v < int'(MinDeadCount));
  endfunction

  // Reference model: works on the sampled stream using timestamps of
  // segment starts and rising edges; results appear one edge later.
  int       cyc = 0;
  int       seg_start = 0;
  int       last_rise = 0;
  logic [1:0] xa = 2'b00;
  logic [1:0] xb = 2'b00;
  logic [1:0] prev_on = 2'b00;
  bit       active = 0;
  bit       seen = 0;
  int       m_hi = 0, m_lo = 0, m_hl = 0, m_lh = 0, m_per = 0;
  bit       m_mv = 0, m_st = 0, m_dv = 0;

  always @(posedge MClk) begin
    bit dset;
    int len;
    dset = 0;
    m_mv = 0;
    if (!RstN) begin
      m_hi = 0; m_lo = 0; m_hl = 0; m_lh = 0; m_per = 0;
      m_st = 0; m_dv = 0;
      xa = S; xb = S;
      active = 0; seen = 0;
    end else begin
      if (!Enable) begin
        active = 0;
        seen = 0;
      end else begin
        if (xa != xb) begin
          len = sat(cyc - 1 - seg_start);
          if (!active) begin
            if (xb != 2'b00) begin
              active = 1;
              prev_on = xb;
            end
          end else begin
            if (xa == 2'b10 && xb != 2'b11) m_hi = len;
            if (xa == 2'b01 && xb != 2'b11) m_lo = len;
            if (xb == 2'b01 && (xa == 2'b10 || (xa == 2'b00 && prev_on == 2'b10))) begin
              m_hl = (xa == 2'b10) ? 0 : len;
              if (below(m_hl)) dset = 1;
            end
            if (xb == 2'b10 && (xa == 2'b01 || (xa == 2'b00 && prev_on == 2'b01))) begin
              m_lh = (xa == 2'b01) ? 0 : len;
              if (below(m_lh)) dset = 1;
            end
            if (xa == 2'b11 && xb == 2'b00) active = 0;
            if (xb != 2'b00) prev_on = xb;
          end
        end
        if (xb[1] && !xa[1]) begin
          if (seen) begin
            m_per = sat(cyc - 1 - last_rise);
            m_mv = 1;
          end
          seen = 1;
          last_rise = cyc - 1;
        end
      end
      if (xa != xb) seg_start = cyc - 1;
      if (FaultClr) begin
        m_st = 0;
        m_dv = 0;
      end
      if (xb == 2'b11) m_st = 1;
      if (dset) m_dv = 1;
      xa = xb;
      xb = S;
    end
    cyc++;
    #1;
    check("HighTimeHi", int'(HighTimeHi), m_hi);
    check("HighTimeLo", int'(HighTimeLo), m_lo);
    check("DeadTimeHL", int'(DeadTimeHL), m_hl);
    check("DeadTimeLH", int'(DeadTimeLH), m_lh);
    check("Period",     int'(Period),     m_per);
    check("MeasValid",  int'(MeasValid),  int'(m_mv));
    check("ShootThru",  int'(ShootThru),  int'(m_st));
    check("DeadViol",   int'(DeadViol),   int'(m_dv));
    check("Fault",      int'(Fault),      int'(m_st | m_dv));
    if (MeasValid) mv_count++;
  end

  task automatic hold(input logic [1:0] s, input int n);
    S = s;
    repeat (n) @(negedge MClk);
  endtask

  task automatic pattern(input int h, input int dh, input int l, input int dl);
    hold(2'b10, h);
    hold(2'b00, dh);
    hold(2'b01, l);
    hold(2'b00, dl);
  endtask

  task automatic pulse_clr();
    FaultClr = 1'b1;
    @(negedge MClk);
    FaultClr = 1'b0;
  endtask

  initial begin
    RstN = 1'b0; S = 2'b10; Enable = 1'b0; MinDeadCount = '0; FaultClr = 1'b0;
    repeat (4) @(negedge MClk);
    RstN = 1'b1;
    repeat (3) @(negedge MClk);
    check("rst_HighTimeHi", int'(HighTimeHi), 0);
    check("rst_Period", int'(Period), 0);
    check("rst_MeasValid", int'(MeasValid), 0);
    check("rst_Fault", int'(Fault), 0);

    // Nominal pattern: 50 high, 10 dead, 40 low, 10 dead
    MinDeadCount = W'(10);
    Enable = 1'b1;
    hold(2'b00, 5);
    mv0 = mv_count;
    repeat (3) pattern(50, 10, 40, 10);
    check("nom_HighTimeHi", int'(HighTimeHi), 50);
    check("nom_HighTimeLo", int'(HighTimeLo), 40);
    check("nom_DeadTimeHL", int'(DeadTimeHL), 10);
    check("nom_DeadTimeLH", int'(DeadTimeLH), 10);
    check("nom_Period", int'(Period), 110);
    check("nom_mv_pulses", mv_count - mv0, 2);
    check("nom_Fault", int'(Fault), 0);

    // 9-cycle gap: violation appears one cycle after the 01 sample
    hold(2'b10, 50);
    hold(2'b00, 9);
    S = 2'b01;
    @(posedge MClk); #2;
    check("short_DeadViol_early", int'(DeadViol), 0);
    @(posedge MClk); #2;
    check("short_DeadViol", int'(DeadViol), 1);
    check("short_DeadTimeHL", int'(DeadTimeHL), 9);
    repeat (39) @(negedge MClk);
    hold(2'b00, 10);
    check("short_Fault", int'(Fault), 1);
    pulse_clr();
    check("clr_DeadViol", int'(DeadViol), 0);

    // Direct 10 -> 01 handover
    hold(2'b10, 50);
    hold(2'b01, 40);
    hold(2'b00, 10);
    check("direct_DeadTimeHL", int'(DeadTimeHL), 0);
    check("direct_DeadViol", int'(DeadViol), 1);
    pulse_clr();

    // Shoot-through while disabled, clear, and set-over-clear
    Enable = 1'b0;
    hold(2'b00, 3);
    hold(2'b11, 1);
    hold(2'b00, 2);
    check("st_ShootThru", int'(ShootThru), 1);
    check("st_Fault", int'(Fault), 1);
    pulse_clr();
    check("st_clr_ShootThru", int'(ShootThru), 0);
    check("st_clr_Fault", int'(Fault), 0);
    S = 2'b11; FaultClr = 1'b1;
    @(negedge MClk);
    S = 2'b00;
    @(negedge MClk);
    FaultClr = 1'b0;
    check("st_setwins_ShootThru", int'(ShootThru), 1);
    pulse_clr();

    // Enable drop mid-pattern
    Enable = 1'b1;
    hold(2'b00, 5);
    repeat (2) pattern(50, 10, 40, 10);
    hold(2'b10, 50);
    hold(2'b00, 10);
    hold(2'b01, 20);
    Enable = 1'b0;
    repeat (5) @(negedge MClk);
    check("drop_Period", int'(Period), 110);
    check("drop_HighTimeHi", int'(HighTimeHi), 50);
    check("drop_DeadTimeHL", int'(DeadTimeHL), 10);
    Enable = 1'b1;
    mv0 = mv_count;
    hold(2'b01, 15);
    hold(2'b00, 10);
    pattern(30, 10, 20, 10);
    check("restore_first_mv", mv_count - mv0, 0);
    check("restore_Period_kept", int'(Period), 110);
    hold(2'b10, 5);
    hold(2'b00, 3);
    check("restore_second_mv", mv_count - mv0, 1);
    check("restore_Period", int'(Period), 70);
    check("restore_HighTimeLo", int'(HighTimeLo), 20);

    // Saturation of on-time and period
    hold(2'b00, 10);
    hold(2'b10, 70000);
    hold(2'b00, 10);
    check("sat_HighTimeHi", int'(HighTimeHi), MAXV);
    hold(2'b01, 10);
    hold(2'b00, 10);
    hold(2'b10, 5);
    hold(2'b00, 3);
    check("sat_Period", int'(Period), MAXV);
    check("sat_HighTimeLo", int'(HighTimeLo), 10);

    // Reset mid-operation
    hold(2'b10, 7);
    RstN = 1'b0;
    repeat (3) @(negedge MClk);
    RstN = 1'b1;
    @(negedge MClk);
    check("rst2_HighTimeHi", int'(HighTimeHi), 0);
    check("rst2_Period", int'(Period), 0);
    mv0 = mv_count;
    hold(2'b00, 5);
    hold(2'b10, 20);
    hold(2'b00, 5);
    hold(2'b10, 20);
    hold(2'b00, 2);
    check("rst2_mv", mv_count - mv0, 1);
    check("rst2_Period", int'(Period), 25);
    check("rst2_HighTimeHi", int'(HighTimeHi), 20);

    repeat (2) @(negedge MClk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_pair_monitor.md
# gate_pair_monitor

Observes a complementary PWM gate pair after dead-time insertion and measures high-side on-time, low-side on-time, both dead-time gaps and the switching period, all in MClk cycles. It raises sticky faults when both gates are high (shoot-through) or when a dead-time gap is shorter than a programmed minimum. The block sits beside each gate-pair output of the PWM generator and provides on-chip self-check and telemetry for the dead-time path.

## Interface
- CNT_W, 16, width of all counters and measurement outputs

- MClk  in  1  system clock
- RstN  in  1  synchronous, active-low reset
- Enable  in  1  measurement enable; low holds the measurement engine idle
- S  in  2  observed gate pair, S[1] high side, S[0] low side; MClk-synchronous, no synchronizer
- MinDeadCount  in  CNT_W  minimum legal dead time in cycles; 0 disables the dead-time check
- FaultClr  in  1  clears sticky fault flags
- HighTimeHi  out  CNT_W  last completed S=10 segment length
- HighTimeLo  out  CNT_W  last completed S=01 segment length
- DeadTimeHL  out  CNT_W  last gap from the end of 10 to the start of 01
- DeadTimeLH  out  CNT_W  last gap from the end of 01 to the start of 10
- Period  out  CNT_W  cycles between consecutive S[1] rising edges
- MeasValid  out  1  one-cycle pulse when Period updates
- ShootThru  out  1  sticky flag: S=11 sampled
- DeadViol  out  1  sticky flag: measured gap below MinDeadCount
- Fault  out  1  ShootThru | DeadViol

## Operation
- SPrev register holds the previous S. During reset, SPrev loads S so that no spurious edge occurs after reset release.
- Segment counter SegCnt holds the number of cycles the SPrev pattern has been held.
  - When S != SPrev, the completed segment length is SegCnt and SegCnt reloads to 1.
  - Otherwise SegCnt increments.
  - SegCnt saturates at 2^CNT_W-1.
- State machine (state_t), states IDLE, HI_ON (10), DEAD_H (00 after 10), LO_ON (01), DEAD_L (00 after 01), BOTH (11).
  - IDLE: on the first S change with Enable high, go to the state matching the new S. The partial segment in progress is discarded.
  - Leaving HI_ON: HighTimeHi <= SegCnt. Leaving LO_ON: HighTimeLo <= SegCnt.
  - DEAD_H→LO_ON: DeadTimeHL <= SegCnt. DEAD_L→HI_ON: DeadTimeLH <= SegCnt.
  - Direct HI_ON→LO_ON: DeadTimeHL <= 0. Direct LO_ON→HI_ON: DeadTimeLH <= 0.
  - DEAD_H→HI_ON and DEAD_L→LO_ON (same gate returns): no dead-time update, no check.
  - Entering or leaving BOTH: no on-time or dead-time update.
- Dead-time check: on every DeadTime* update, DeadViol sets if MinDeadCount != 0 and the value < MinDeadCount.
- Period counter PerCnt increments every cycle and saturates at 2^CNT_W-1.
  - On an S[1] 0→1 edge, PerCnt reloads to 1.
  - If a previous S[1] rising edge has been seen since enable (FirstSeen flag), also Period <= PerCnt and MeasValid pulses.
- Shoot-through detection runs independently of Enable and the state machine: S=11 sampled in any cycle after reset sets ShootThru.
- FaultClr clears ShootThru and DeadViol. If a set condition occurs in the same cycle as FaultClr, set wins.
- Enable low:
  - state returns to IDLE; SegCnt, PerCnt and FirstSeen clear.
  - Measurement outputs and sticky flags retain their values. ShootThru detection stays active.

## Timing
- Reset values: all measurement outputs, MeasValid, ShootThru, DeadViol and Fault are 0; state is IDLE.
- All outputs are registered. An update caused by the S change sampled at edge N is visible after edge N+1 (1-cycle latency).
- MeasValid is high for exactly one cycle, coincident with the new Period value.
- Fault is a registered OR of the flags, with the same latency as the flags (no extra cycle).
- Reset mid-operation behaves like power-up: FirstSeen clears, so the first post-reset S[1] rising edge does not produce MeasValid.
- Saturated counts report 2^CNT_W-1, never wrap.

## Structure
- Package gate_mon_pkg holds:
  - typedef enum logic [2:0] state_t {IDLE, HI_ON, DEAD_H, LO_ON, DEAD_L, BOTH}
  - localparam CNT_W_DEFAULT = 16
- Sub-module sat_counter (ports: enable, load-to-1, saturating increment, count out), instantiated twice, for SegCnt and PerCnt.

## Test plan
- Reset with S=10 held, then release → all outputs 0, no MeasValid, no fault.
- MinDeadCount=10, Enable=1, repeat 10×50 cycles, 00×10, 01×40, 00×10 → HighTimeHi=50, DeadTimeHL=10, HighTimeLo=40, DeadTimeLH=10, Period=110. MeasValid pulses once per cycle of the pattern, starting at the second S[1] rising edge. Fault=0.
- Same pattern with a 9-cycle 00 gap after 10 → DeadTimeHL=9, DeadViol=1 one cycle after the 01 sample. A direct 10→01 transition → DeadTimeHL=0, DeadViol=1.
- Enable=0 and S=11 for one cycle → ShootThru=1, Fault=1. A FaultClr pulse → both 0. FaultClr asserted in the same cycle as S=11 → ShootThru stays 1.
- CNT_W=16, S=10 held 70000 cycles then 00 → HighTimeHi=65535. Next rising edge → Period=65535.
- Mid-pattern Enable drop for 5 cycles, then restore → outputs retain prior values. The first rising edge after restore gives no MeasValid; the second gives the correct Period.
